multicycle_control: RTL

Multi-cycle control unit for the MIPS datapath, replacing single-cycle combinational opcode decoding. It sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states. It stalls on a memory ready handshake, flags illegal opcodes and counts retired instructions. The opcode map and group ranges are parameters, so an encoding change needs no RTL edits.

---
 rtl/multicycle_control.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences FETCH..WRITEBACK, stalls on mem_ready,
// flags illegal opcodes and counts retired instructions.
module multicycle_control #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned R_LAST   = 6,
    parameter int unsigned I_FIRST  = 7,
    parameter int unsigned I_LAST   = 13,
    parameter int unsigned LW_OP    = 14,
    parameter int unsigned SW_OP    = 15,
    parameter int unsigned BR_OP    = 16,
    parameter int unsigned J_OP     = 17,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_write,
    output logic                ir_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                mem_to_reg,
    output logic                reg_dst,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          pc_source,
    output logic [3:0]          state,
    output logic                illegal,
    output logic                retire,
    output logic [CNT_W-1:0]    instr_count
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StExec    = 4'd2,
        StMemAddr = 4'd3,
        StAluWb   = 4'd4,
        StMemRd   = 4'd5,
        StMemWb   = 4'd6,
        StBranch  = 4'd7,
        StJump    = 4'd8,
        StMemWr   = 4'd9
    } state_e;

    localparam logic [OPCODE_W-1:0] RLast  = OPCODE_W'(R_LAST);
    localparam logic [OPCODE_W-1:0] IFirst = OPCODE_W'(I_FIRST);
    localparam logic [OPCODE_W-1:0] ILast  = OPCODE_W'(I_LAST);
    localparam logic [OPCODE_W-1:0] LwOp   = OPCODE_W'(LW_OP);
    localparam logic [OPCODE_W-1:0] SwOp   = OPCODE_W'(SW_OP);
    localparam logic [OPCODE_W-1:0] BrOp   = OPCODE_W'(BR_OP);
    localparam logic [OPCODE_W-1:0] JOp    = OPCODE_W'(J_OP);

    state_e           r_state;
    logic             r_is_r;
    logic             r_is_lw;
    logic [CNT_W-1:0] r_instr_count;

    logic w_cls_r, w_cls_i, w_cls_lw, w_cls_sw, w_cls_br, w_cls_j, w_cls_none;

    // Priority chain resolves overlapping parameter ranges: R > I > LW > SW > BR > J.
    always_comb begin
        w_cls_r    = (opcode <= RLast);
        w_cls_i    = !w_cls_r && (opcode >= IFirst) && (opcode <= ILast);
        w_cls_lw   = !w_cls_r && !w_cls_i && (opcode == LwOp);
        w_cls_sw   = !w_cls_r && !w_cls_i && !w_cls_lw && (opcode == SwOp);
        w_cls_br   = !w_cls_r && !w_cls_i && !w_cls_lw && !w_cls_sw && (opcode == BrOp);
        w_cls_j    = !w_cls_r && !w_cls_i && !w_cls_lw && !w_cls_sw && !w_cls_br
                     && (opcode == JOp);
        w_cls_none = !(w_cls_r || w_cls_i || w_cls_lw || w_cls_sw || w_cls_br || w_cls_j);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= StFetch;
            r_is_r        <= 1'b0;
            r_is_lw       <= 1'b0;
            r_instr_count <= '0;
        end else begin
            if (retire) begin
                r_instr_count <= r_instr_count + 1'b1;
            end
            case (r_state)
                StFetch:   if (mem_ready) r_state <= StDecode;
                StDecode: begin
                    r_is_r  <= w_cls_r;
                    r_is_lw <= w_cls_lw;
                    if (w_cls_r || w_cls_i)       r_state <= StExec;
                    else if (w_cls_lw || w_cls_sw) r_state <= StMemAddr;
                    else if (w_cls_br)             r_state <= StBranch;
                    else if (w_cls_j)              r_state <= StJump;
                    else                           r_state <= StFetch;
                end
                StExec:    r_state <= StAluWb;
                StMemAddr: r_state <= r_is_lw ? StMemRd : StMemWr;
                StMemRd:   if (mem_ready) r_state <= StMemWb;
                StMemWr:   if (mem_ready) r_state <= StFetch;
                default:   r_state <= StFetch;
            endcase
        end
    end

    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        i_or_d     = 1'b0;
        mem_to_reg = 1'b0;
        reg_dst    = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        pc_source  = 2'b00;
        illegal    = 1'b0;
        retire     = 1'b0;
        case (r_state)
            StFetch: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            StDecode: begin
                alu_src_b = 2'b11;
                illegal   = w_cls_none;
            end
            StExec: begin
                alu_src_a = 1'b1;
                alu_src_b = r_is_r ? 2'b00 : 2'b10;
                alu_op    = r_is_r ? 2'b10 : 2'b11;
            end
            StMemAddr: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            StAluWb: begin
                reg_write = 1'b1;
                reg_dst   = r_is_r;
                retire    = 1'b1;
            end
            StMemRd: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            StMemWb: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire     = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                pc_source = 2'b01;
                pc_write  = zero;
                retire    = 1'b1;
            end
            StJump: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
                retire    = 1'b1;
            end
            StMemWr: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                retire    = mem_ready;
            end
            default: ;
        endcase
        // Strobes are masked during reset; selects keep their FETCH values.
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            retire    = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign state       = r_state;
    assign instr_count = r_instr_count;

endmodule
